// File: rtl/bsg_fpu_round_rshift.sv
// Multi-cycle right shift with guard/sticky tracking and round-to-nearest-even.
// One transaction in flight: shifts 4 bits/cycle then 1 bit/cycle, rounds, holds result until yumi_i.
module bsg_fpu_round_rshift #(
  parameter int width_p        = 16,
  parameter int shamt_width_lp = $clog2(width_p) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  input  logic [shamt_width_lp-1:0] shamt_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  output logic                      inexact_o,
  output logic                      inc_o,
  input  logic                      yumi_i
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;

  localparam logic [shamt_width_lp-1:0] max_shift_lp = shamt_width_lp'(width_p + 1);
  localparam logic [shamt_width_lp-1:0] step4_lp     = shamt_width_lp'(4);
  localparam logic [shamt_width_lp-1:0] step1_lp     = shamt_width_lp'(1);

  state_e state_q, state_d;

  logic [width_p-1:0]        q_q, q_d;
  logic                      g_q, g_d;
  logic                      s_q, s_d;
  logic [shamt_width_lp-1:0] r_q, r_d;
  logic [width_p-1:0]        data_q, data_d;
  logic                      inc_q, inc_d;
  logic                      inexact_q, inexact_d;

  logic                      accept;
  logic [shamt_width_lp-1:0] n_eff;
  logic                      big_step;
  logic [shamt_width_lp-1:0] r_step;
  logic                      up;

  // Shifts past width_p+1 all collapse to "everything is sticky"
  assign n_eff    = (shamt_i > max_shift_lp) ? max_shift_lp : shamt_i;
  assign accept   = v_i & ready_o;
  assign big_step = (r_q >= step4_lp);
  assign r_step   = big_step ? (r_q - step4_lp) : (r_q - step1_lp);
  assign up       = g_q & (s_q | q_q[0]);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (n_eff != '0) ? SHIFT : ROUND;
      SHIFT:   if (r_step == '0) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE) & ~reset_i;
    v_o     = (state_q == DONE);
  end

  always_comb begin
    q_d       = q_q;
    g_d       = g_q;
    s_d       = s_q;
    r_d       = r_q;
    data_d    = data_q;
    inc_d     = inc_q;
    inexact_d = inexact_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          q_d = data_i;
          g_d = 1'b0;
          s_d = 1'b0;
          r_d = n_eff;
        end
      end
      SHIFT: begin
        r_d = r_step;
        if (big_step) begin
          s_d = s_q | g_q | (|q_q[2:0]);
          g_d = q_q[3];
          q_d = q_q >> 4;
        end else begin
          s_d = s_q | g_q;
          g_d = q_q[0];
          q_d = q_q >> 1;
        end
      end
      ROUND: begin
        // q + up cannot wrap: any nonzero shift clears the top bit, and n=0 leaves g clear
        data_d    = q_q + width_p'(up);
        inc_d     = up;
        inexact_d = g_q | s_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_q       <= '0;
      g_q       <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= '0;
      data_q    <= '0;
      inc_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      g_q       <= g_d;
      s_q       <= s_d;
      r_q       <= r_d;
      data_q    <= data_d;
      inc_q     <= inc_d;
      inexact_q <= inexact_d;
    end
  end

  assign data_o    = data_q;
  assign inc_o     = inc_q;
  assign inexact_o = inexact_q;

endmodule
